// File: rtl/bisection_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bisection_pkg
//  Purpose  : Shared types, widths and helpers for the bisection search family.
//  Revision : 1.0 - initial release
// ============================================================================
package bisection_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_APPLY = 3'd1,
        S_WAIT  = 3'd2,
        S_EVAL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int unsigned c_def_bus_width = 10;
    localparam int unsigned c_def_iter_w    = $clog2(c_def_bus_width + 2 + 1);

    function automatic int unsigned iter_width(input int unsigned max_iter);
        return $clog2(max_iter + 1);
    endfunction

    // lo + half the span never overflows as long as lo <= hi
    function automatic logic [31:0] midpoint(input logic [31:0] lo, input logic [31:0] hi);
        return lo + ((hi - lo) >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bisection_abs_err.sv
`default_nettype none
// ============================================================================
//  Module   : bisection_abs_err
//  Purpose  : Signed difference a-b and its unsigned magnitude, BUS_WIDTH+1 wide.
//  Revision : 1.0 - initial release
// ============================================================================
module bisection_abs_err
    import bisection_pkg::*;
#(
    parameter int BUS_WIDTH = c_def_bus_width
) (
    input  logic        [BUS_WIDTH-1:0] i_a,
    input  logic        [BUS_WIDTH-1:0] i_b,
    output logic signed [BUS_WIDTH:0]   o_diff,
    output logic        [BUS_WIDTH:0]   o_mag
);

    always_comb begin
        o_diff = $signed({1'b0, i_a}) - $signed({1'b0, i_b});
        o_mag  = o_diff[BUS_WIDTH] ? $unsigned(-o_diff) : $unsigned(o_diff);
    end

endmodule
`default_nettype wire

// File: rtl/bisection_search.sv
`default_nettype none
// ============================================================================
//  Module   : bisection_search
//  Purpose  : Integer bisection of the reference-current code towards a target
//             quality value, with tolerance, exhaustion and iteration limits.
//  Revision : 1.0 - initial release
// ============================================================================
module bisection_search
    import bisection_pkg::*;
#(
    parameter int BUS_WIDTH = c_def_bus_width,
    parameter int TOL       = 1,
    parameter int MAX_ITER  = BUS_WIDTH + 2,
    parameter bit INVERT    = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_start,
    input  logic [BUS_WIDTH-1:0]              i_i_ref_min,
    input  logic [BUS_WIDTH-1:0]              i_i_ref_max,
    input  logic [BUS_WIDTH-1:0]              i_q_desired,
    input  logic [BUS_WIDTH-1:0]              i_q_measured,
    input  logic                              i_ready,
    output logic                              o_meas_req,
    output logic [BUS_WIDTH-1:0]              o_i_ref,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_converged,
    output logic                              o_timeout,
    output logic                              o_bound_err,
    output logic [iter_width(MAX_ITER)-1:0]   o_iter_count
);

    localparam int unsigned            c_iter_w   = iter_width(MAX_ITER);
    localparam logic [BUS_WIDTH:0]     c_tol      = (BUS_WIDTH+1)'(TOL);
    localparam logic [c_iter_w-1:0]    c_max_iter = c_iter_w'(MAX_ITER);
    localparam logic [BUS_WIDTH-1:0]   c_one      = BUS_WIDTH'(1);

    state_t                r_state, w_state_nxt;
    logic [BUS_WIDTH-1:0]  r_a, r_b, r_c, r_qd, r_qm, r_best_c, r_i_ref;
    logic [BUS_WIDTH-1:0]  w_a_nxt, w_b_nxt, w_c_nxt, w_qd_nxt, w_qm_nxt, w_best_c_nxt, w_i_ref_nxt;
    logic [BUS_WIDTH:0]    r_best_err, w_best_err_nxt;
    logic [c_iter_w-1:0]   r_iter, w_iter_nxt, w_iter_inc;
    logic                  r_meas_req, r_busy, r_done, r_conv, r_to, r_be;
    logic                  w_meas_req_nxt, w_conv_nxt, w_to_nxt, w_be_nxt;

    logic signed [BUS_WIDTH:0] w_diff;
    logic [BUS_WIDTH:0]    w_mag;
    logic [BUS_WIDTH-1:0]  w_mid_start, w_mid_up, w_mid_down, w_best_sel;
    logic                  w_below, w_better;

    bisection_abs_err #(.BUS_WIDTH(BUS_WIDTH)) u_abs_err (
        .i_a    (r_qm),
        .i_b    (r_qd),
        .o_diff (w_diff),
        .o_mag  (w_mag)
    );

    assign w_mid_start = BUS_WIDTH'(midpoint(32'(i_i_ref_min), 32'(i_i_ref_max)));
    assign w_mid_up    = BUS_WIDTH'(midpoint(32'(r_c), 32'(r_b)));
    assign w_mid_down  = BUS_WIDTH'(midpoint(32'(r_a), 32'(r_c)));
    assign w_below     = w_diff[BUS_WIDTH] ^ INVERT;
    assign w_better    = (w_mag < r_best_err);
    // the candidate being evaluated wins only on a strictly smaller error
    assign w_best_sel  = w_better ? r_c : r_best_c;
    assign w_iter_inc  = r_iter + c_iter_w'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_c_nxt        = r_c;
        w_qd_nxt       = r_qd;
        w_qm_nxt       = r_qm;
        w_best_c_nxt   = r_best_c;
        w_best_err_nxt = r_best_err;
        w_i_ref_nxt    = r_i_ref;
        w_iter_nxt     = r_iter;
        w_meas_req_nxt = 1'b0;
        w_conv_nxt     = r_conv;
        w_to_nxt       = r_to;
        w_be_nxt       = r_be;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_a_nxt        = i_i_ref_min;
                    w_b_nxt        = i_i_ref_max;
                    w_qd_nxt       = i_q_desired;
                    w_best_err_nxt = '1;
                    w_iter_nxt     = '0;
                    w_conv_nxt     = 1'b0;
                    w_to_nxt       = 1'b0;
                    w_be_nxt       = 1'b0;
                    if (i_i_ref_min > i_i_ref_max) begin
                        w_be_nxt    = 1'b1;
                        w_i_ref_nxt = i_i_ref_min;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_c_nxt        = w_mid_start;
                        w_i_ref_nxt    = w_mid_start;
                        w_meas_req_nxt = 1'b1;
                        w_state_nxt    = S_APPLY;
                    end
                end
            end
            S_APPLY: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_ready) begin
                    w_qm_nxt    = i_q_measured;
                    w_state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                w_iter_nxt = w_iter_inc;
                if (w_better) begin
                    w_best_c_nxt   = r_c;
                    w_best_err_nxt = w_mag;
                end
                if (w_mag <= c_tol) begin
                    w_conv_nxt  = 1'b1;
                    w_i_ref_nxt = w_best_sel;
                    w_state_nxt = S_DONE;
                end else if (w_iter_inc == c_max_iter) begin
                    w_to_nxt    = 1'b1;
                    w_i_ref_nxt = w_best_sel;
                    w_state_nxt = S_DONE;
                end else if ((r_b - r_a) <= c_one) begin
                    w_i_ref_nxt = w_best_sel;
                    w_state_nxt = S_DONE;
                end else begin
                    if (w_below) begin
                        w_a_nxt = r_c;
                        w_c_nxt = w_mid_up;
                    end else begin
                        w_b_nxt = r_c;
                        w_c_nxt = w_mid_down;
                    end
                    w_i_ref_nxt    = w_c_nxt;
                    w_meas_req_nxt = 1'b1;
                    w_state_nxt    = S_APPLY;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_qd       <= '0;
            r_qm       <= '0;
            r_best_c   <= '0;
            r_best_err <= '1;
            r_i_ref    <= '0;
            r_iter     <= '0;
            r_meas_req <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_conv     <= 1'b0;
            r_to       <= 1'b0;
            r_be       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_c        <= w_c_nxt;
            r_qd       <= w_qd_nxt;
            r_qm       <= w_qm_nxt;
            r_best_c   <= w_best_c_nxt;
            r_best_err <= w_best_err_nxt;
            r_i_ref    <= w_i_ref_nxt;
            r_iter     <= w_iter_nxt;
            r_meas_req <= w_meas_req_nxt;
            r_busy     <= (w_state_nxt == S_APPLY) || (w_state_nxt == S_WAIT) || (w_state_nxt == S_EVAL);
            r_done     <= (w_state_nxt == S_DONE);
            r_conv     <= w_conv_nxt;
            r_to       <= w_to_nxt;
            r_be       <= w_be_nxt;
        end
    end

    assign o_meas_req   = r_meas_req;
    assign o_i_ref      = r_i_ref;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_converged  = r_conv;
    assign o_timeout    = r_to;
    assign o_bound_err  = r_be;
    assign o_iter_count = r_iter;

endmodule
`default_nettype wire
